// File: rtl/rst_seq_pkg.sv
// Shared types and limits for the reset domain sequencer.
// State encoding plus minimum legal values for the timing parameters.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DLY,
        CKG_LEAD,
        DONE,
        SW_DOM,
        SW_HOLD,
        SW_DLY,
        SW_LEAD
    } rst_seq_state_e;

    localparam int MinCkgLead    = 1;
    localparam int MinHoldCycles = 1;

endpackage

// File: rtl/rst_seq_cnt.sv
// Loadable down-counter shared by every sequencer state.
// Load has priority over decrement; is_zero is purely combinational.
module rst_seq_cnt
    import rst_seq_pkg::*;
#(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             dec,
    output logic             is_zero
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/rst_domain_sequencer.sv
// Per-domain reset release sequencer with software re-reset handshake.
// Optional test bypass of all reset outputs: RST_SEQ_TEST_BYPASS_EN.
`ifdef RST_SEQ_TEST_BYPASS_EN
module hard_mux2 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    assign y = sel ? b : a;
endmodule
`endif

module rst_domain_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NumDomains = 4,
    parameter int CntWidth   = 8,
    parameter int CkgLead    = 2,
    parameter int HoldCycles = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [NumDomains*CntWidth-1:0] dly_i,
    input  logic [NumDomains-1:0]          sw_req_i,
`ifdef RST_SEQ_TEST_BYPASS_EN
    input  logic                           test_mode_i,
    input  logic                           rst_test_ni,
`endif
    output logic [NumDomains-1:0]          sw_ack_o,
    output logic [NumDomains-1:0]          rst_dom_no,
    output logic [NumDomains-1:0]          rst_ckg_no,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int IdxW = (NumDomains > 1) ? $clog2(NumDomains) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumDomains - 1);
    localparam logic [CntWidth-1:0] LeadLd = CntWidth'(CkgLead - 1);
    localparam logic [CntWidth-1:0] HoldLd = CntWidth'(HoldCycles - 1);

    if (CkgLead < MinCkgLead) begin : g_bad_lead
        $error("CkgLead below minimum");
    end
    if (HoldCycles < MinHoldCycles) begin : g_bad_hold
        $error("HoldCycles below minimum");
    end

    rst_seq_state_e state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d, nxt, sel;
    logic [NumDomains-1:0] dom_q, dom_d, ckg_q, ckg_d, ack_q, ack_d;
    logic done_q, done_d;
    logic cnt_load, cnt_dec, cnt_zero;
    logic [CntWidth-1:0] cnt_val;
    logic [CntWidth-1:0] dly_f [NumDomains];

    always_comb begin
        for (int i = 0; i < NumDomains; i++) begin
            dly_f[i] = dly_i[i*CntWidth +: CntWidth];
        end
    end

    // Lowest pending request index wins.
    always_comb begin
        sel = '0;
        for (int i = NumDomains - 1; i >= 0; i--) begin
            if (sw_req_i[i]) sel = IdxW'(i);
        end
    end

    rst_seq_cnt #(.Width(CntWidth)) u_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (cnt_load),
        .load_val(cnt_val),
        .dec     (cnt_dec),
        .is_zero (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dom_d    = dom_q;
        ckg_d    = ckg_q;
        ack_d    = '0;
        done_d   = done_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        nxt      = idx_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = WAIT_DLY;
                    idx_d    = '0;
                    cnt_load = 1'b1;
                    cnt_val  = dly_f[0];
                end
            end
            WAIT_DLY, SW_DLY: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    ckg_d[idx_q] = 1'b1;
                    state_d  = (state_q == WAIT_DLY) ? CKG_LEAD : SW_LEAD;
                    cnt_load = 1'b1;
                    cnt_val  = LeadLd;
                end
            end
            CKG_LEAD: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    dom_d[idx_q] = 1'b1;
                    if (idx_q == LastIdx) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d    = nxt;
                        state_d  = WAIT_DLY;
                        cnt_load = 1'b1;
                        cnt_val  = dly_f[nxt];
                    end
                end
            end
            SW_LEAD: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    dom_d[idx_q] = 1'b1;
                    ack_d[idx_q] = 1'b1;
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                if (|sw_req_i) begin
                    idx_d      = sel;
                    dom_d[sel] = 1'b0;
                    done_d     = 1'b0;
                    state_d    = SW_DOM;
                    cnt_load   = 1'b1;
                    cnt_val    = LeadLd;
                end
            end
            SW_DOM: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    ckg_d[idx_q] = 1'b0;
                    state_d  = SW_HOLD;
                    cnt_load = 1'b1;
                    cnt_val  = HoldLd;
                end
            end
            SW_HOLD: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    state_d  = SW_DLY;
                    cnt_load = 1'b1;
                    cnt_val  = dly_f[idx_q];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dom_q   <= '0;
            ckg_q   <= '0;
            ack_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            ckg_q   <= ckg_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    assign sw_ack_o = ack_q;
    assign done_o   = done_q;
    assign busy_o   = (state_q != IDLE) && (state_q != DONE);

`ifdef RST_SEQ_TEST_BYPASS_EN
    for (genvar i = 0; i < NumDomains; i++) begin : g_byp
        hard_mux2 u_dom (
            .a  (dom_q[i]),
            .b  (rst_test_ni),
            .sel(test_mode_i),
            .y  (rst_dom_no[i])
        );
        hard_mux2 u_ckg (
            .a  (ckg_q[i]),
            .b  (rst_test_ni),
            .sel(test_mode_i),
            .y  (rst_ckg_no[i])
        );
    end
`else
    assign rst_dom_no = dom_q;
    assign rst_ckg_no = ckg_q;
`endif

endmodule

// File: tb/tb_rst_domain_sequencer.sv
// Directed bench for rst_domain_sequencer with an expectation queue.
// Expected output vectors are derived from the release timing formulas.
module tb_rst_domain_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dly = '0;
    logic [3:0]  req = '0;
    logic [3:0]  ack, dom, ckg;
    logic        busy, done;
`ifdef RST_SEQ_TEST_BYPASS_EN
    logic        tmode = 1'b0;
    logic        trst = 1'b0;
`endif

    rst_domain_sequencer #(
        .NumDomains(4),
        .CntWidth  (8),
        .CkgLead   (2),
        .HoldCycles(4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .dly_i      (dly),
        .sw_req_i   (req),
`ifdef RST_SEQ_TEST_BYPASS_EN
        .test_mode_i(tmode),
        .rst_test_ni(trst),
`endif
        .sw_ack_o   (ack),
        .rst_dom_no (dom),
        .rst_ckg_no (ckg),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [13:0] v;
        string       tag;
    } exp_t;

    exp_t q[$];
    int ecnt = 0;
    int total = 0;
    int pass_cnt = 0;

    function automatic logic [13:0] pack(logic [3:0] d, logic [3:0] c,
                                         logic [3:0] a, logic b, logic dn);
        return {d, c, a, b, dn};
    endfunction

    task automatic chk(string tag, logic [13:0] expv);
        logic [13:0] obs;
        obs = {dom, ckg, ack, busy, done};
        total++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s edge=%0d observed=%b required=%b (dom,ckg,ack,busy,done)",
                    tag, ecnt, obs, expv);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        ecnt++;
        #1;
        while (q.size() > 0 && q[0].cyc <= ecnt) begin
            e = q.pop_front();
            chk(e.tag, e.v);
        end
    endtask

    // Power-up order: ckg[i] at d+1+(d+3)i, dom[i] at d+3+(d+3)i.
    task automatic push_seq(int b, int d, int last, string nm);
        logic [3:0] dv, cv;
        int per;
        per = d + 3;
        for (int e = 0; e <= last; e++) begin
            for (int i = 0; i < 4; i++) begin
                cv[i] = (e >= d + 1 + per * i);
                dv[i] = (e >= d + 3 + per * i);
            end
            q.push_back('{b + e, pack(dv, cv, 4'b0, e < 4 * per, e >= 4 * per),
                          $sformatf("%s_e%0d", nm, e)});
        end
    endtask

    // SW re-reset of domain k starting at edge t with delay d.
    task automatic push_sw(int t, int k, int d, string nm);
        logic [3:0] dv, cv, av;
        for (int e = 0; e <= 9 + d; e++) begin
            dv = 4'hF;
            cv = 4'hF;
            av = 4'h0;
            if (e < 9 + d) dv[k] = 1'b0;
            if (e >= 2 && e < 7 + d) cv[k] = 1'b0;
            if (e == 9 + d) av[k] = 1'b1;
            q.push_back('{t + e, pack(dv, cv, av, e < 9 + d, e == 9 + d),
                          $sformatf("%s_e%0d", nm, e)});
        end
    endtask

    initial begin
        int b, t1, t2, b2;

        repeat (2) step();
        chk("reset", '0);
        #2 rst = 1'b0;

        // Power-up with dly=3, start held high through DONE
        dly = {4{8'd3}};
        start = 1'b1;
        b = ecnt + 1;
        push_seq(b, 3, 30, "pwr");
        step();
        step();
        dly[7:0] = 8'd9;
        while (ecnt < b + 30) step();

        // SW re-reset of domains 1 then 2
        dly[15:8] = 8'd5;
        t1 = ecnt + 1;
        t2 = t1 + 15;
        req = 4'b0110;
        push_sw(t1, 1, 5, "sw1");
        push_sw(t2, 2, 3, "sw2");
        q.push_back('{t2 + 13, pack(4'hF, 4'hF, 4'h0, 1'b0, 1'b1), "sw_end"});
        while (ecnt < t1 + 14) step();
        req = 4'b0100;
        while (ecnt < t2 + 12) step();
        req = 4'b0000;
        step();

        // Asynchronous reset while in DONE
        start = 1'b0;
        #2 rst = 1'b1;
        #1 chk("rst_in_done", '0);
        #2 rst = 1'b0;

        // Replay, then reset mid CKG_LEAD of domain 2
        dly = {4{8'd3}};
        start = 1'b1;
        b = ecnt + 1;
        push_seq(b, 3, 16, "rep");
        step();
        start = 1'b0;
        while (ecnt < b + 16) step();
        #2 rst = 1'b1;
        #1 chk("mid_rst", '0);
        step();
        chk("mid_rst_hold", '0);
        #2 rst = 1'b0;

        // Zero delay replay with an early SW request
        dly = '0;
        start = 1'b1;
        b2 = ecnt + 1;
        push_seq(b2, 0, 12, "zd");
        step();
        start = 1'b0;
        step();
        req = 4'b0001;
        push_sw(b2 + 13, 0, 0, "swp");
        q.push_back('{b2 + 23, pack(4'hF, 4'hF, 4'h0, 1'b0, 1'b1), "swp_end"});
        while (ecnt < b2 + 22) step();
        req = 4'b0000;
        step();

        total++;
        assert (q.size() == 0) pass_cnt++;
        else $error("FAIL queue_drain observed=%0d required=0", q.size());

`ifdef RST_SEQ_TEST_BYPASS_EN
        tmode = 1'b1;
        trst = 1'b0;
        #1 chk("byp_low", pack(4'h0, 4'h0, 4'h0, 1'b0, 1'b1));
        trst = 1'b1;
        #1 chk("byp_high", pack(4'hF, 4'hF, 4'h0, 1'b0, 1'b1));
        trst = 1'b0;
        #1 chk("byp_low2", pack(4'h0, 4'h0, 4'h0, 1'b0, 1'b1));
        tmode = 1'b0;
        #1 chk("byp_off", pack(4'hF, 4'hF, 4'h0, 1'b0, 1'b1));
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
